// File: rtl/mult_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Booth digit flags: a digit is zero, +-M or +-2M.
  localparam logic [2:0] NEG = 3'b100;
  localparam logic [2:0] ONE = 3'b010;
  localparam logic [2:0] TWO = 3'b001;

  // One radix-4 digit per iteration, covering WIDTH bits plus the
  // two extension bits that keep unsigned operands positive.
  function automatic int calc_iter(input int width);
    return (width + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit encoder: three overlapping multiplier bits in,
// sign / magnitude-one / magnitude-two flags out.
module booth_r4_encoder
  import mult_pkg::*;
(
  input  logic [2:0] bits,
  output logic       neg,
  output logic       one,
  output logic       two
);

  logic [2:0] flags;

  // Map the bit triple {q[2i+1], q[2i], q[2i-1]} onto its signed digit.
  always_comb begin
    flags = 3'b000;
    case (bits)
      3'b001, 3'b010: flags = ONE;
      3'b011:         flags = TWO;
      3'b100:         flags = NEG | TWO;
      3'b101, 3'b110: flags = NEG | ONE;
      default:        flags = 3'b000;
    endcase
  end

  assign neg = |(flags & NEG);
  assign one = |(flags & ONE);
  assign two = |(flags & TWO);

endmodule

// File: rtl/booth_r4_multiplier.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes on both
// sides. One partial product is accumulated per cycle; the full product
// is registered when the block enters DONE and held until the next result.
module booth_r4_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER = calc_iter(WIDTH);
  localparam int PW   = 2 * WIDTH + 2;
  localparam int QW   = WIDTH + 3;
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(ITER);

  state_t          state;
  logic [PW-1:0]   m;
  logic [PW-1:0]   p;
  logic [QW-1:0]   q;
  logic [CW-1:0]   cnt;

  logic [2:0]      window;
  logic            neg;
  logic            one;
  logic            two;
  logic [PW-1:0]   mag;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   p_next;
  logic            a_ext;
  logic            b_ext;

  assign a_ext = is_signed & a[WIDTH-1];
  assign b_ext = is_signed & b[WIDTH-1];

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  booth_r4_encoder u_enc (
    .bits (window),
    .neg  (neg),
    .one  (one),
    .two  (two)
  );

  // Pick the current digit window and form the shifted partial product.
  always_comb begin
    window = 3'(q >> (2 * cnt));
    mag    = '0;
    if (two) begin
      mag = m << 1;
    end else if (one) begin
      mag = m;
    end
    pp     = neg ? ('0 - mag) : mag;
    p_next = p + (pp << (2 * cnt));
  end

  // Handshake FSM with accumulator; en freezes everything, rst aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      m       <= '0;
      q       <= '0;
      p       <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (en) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            m     <= {{(WIDTH + 2){a_ext}}, a};
            q     <= {{2{b_ext}}, b, 1'b0};
            p     <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == LAST) begin
            state   <= DONE;
            product <= p[2*WIDTH-1:0];
          end else begin
            p   <= p_next;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Self-checking bench for booth_r4_multiplier (WIDTH = 32): directed
// vector table, random operands against an arithmetic model, and
// hand-written backpressure / clock-enable / reset sequences.
module tb_booth_r4_multiplier;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 18;
  localparam int BUDGET  = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] expected;
  } vec_t;

  vec_t vecs[10];

  booth_r4_multiplier #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference: plain full-width multiplication of the extended operands.
  function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic [63:0]        ux;
    logic [63:0]        uy;
    if (s) begin
      sx = {{32{x[31]}}, x};
      sy = {{32{y[31]}}, y};
      return 64'(sx * sy);
    end
    ux = {32'b0, x};
    uy = {32'b0, y};
    return ux * uy;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y, input logic s);
    checkOutput("in_ready_before_accept", 64'(in_ready), 64'd1);
    a         = x;
    b         = y;
    is_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
  endtask

  task automatic waitResult(output logic [63:0] prod, output int lat);
    lat  = 0;
    prod = '0;
    while (lat < BUDGET) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    prod = product;
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] res;
    logic [63:0] exp_val;
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic        seen;
    int          lat;

    vecs[0] = '{"s_12_x_m32",     32'd12,         32'hFFFF_FFE0, 1'b1, 64'hFFFF_FFFF_FFFF_FE80};
    vecs[1] = '{"s_m51_x_m4",     32'hFFFF_FFCD,  32'hFFFF_FFFC, 1'b1, 64'd204};
    vecs[2] = '{"s_m1_x_m1",      32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b1, 64'd1};
    vecs[3] = '{"s_0_x_1234",     32'd0,          32'd1234,      1'b1, 64'd0};
    vecs[4] = '{"u_ones_x_ones",  32'hFFFF_FFFF,  32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001};
    vecs[5] = '{"s_min_x_min",    32'h8000_0000,  32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000};
    vecs[6] = '{"s_max_x_min",    32'h7FFF_FFFF,  32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000};
    vecs[7] = '{"u_msb_x_msb",    32'h8000_0000,  32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000};
    vecs[8] = '{"u_ones_x_2",     32'hFFFF_FFFF,  32'd2,         1'b0, 64'h0000_0001_FFFF_FFFE};
    vecs[9] = '{"s_m7_x_3",       32'hFFFF_FFF9,  32'd3,         1'b1, 64'hFFFF_FFFF_FFFF_FFEB};

    rst       = 1'b1;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_product",   product,        64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s);
      waitResult(res, lat);
      checkOutput(vecs[i].name, res, vecs[i].expected);
      checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(LATENCY));
      releaseResult();
    end

    for (int i = 0; i < 40; i++) begin
      x = $urandom;
      y = $urandom;
      s = 1'($urandom_range(0, 1));
      if (i % 4 == 1) x = x >> $urandom_range(16, 31);
      if (i % 4 == 2) y = y >> $urandom_range(16, 31);
      exp_val = ref_product(x, y, s);
      applyStimulus(x, y, s);
      waitResult(res, lat);
      checkOutput("random_product", res, exp_val);
      checkOutput("random_latency", 64'(lat), 64'(LATENCY));
      releaseResult();
    end

    // in_valid held during RUN must not disturb the running operation.
    applyStimulus(32'd7, 32'd9, 1'b0);
    a        = 32'd100;
    b        = 32'd100;
    in_valid = 1'b1;
    waitResult(res, lat);
    in_valid = 1'b0;
    checkOutput("run_ignores_in_valid", res, 64'd63);
    repeat (5) begin
      @(posedge clk);
      #1;
      checkOutput("bp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("bp_product",   product,        64'd63);
      checkOutput("bp_in_ready",  64'(in_ready),  64'd0);
    end
    releaseResult();
    checkOutput("bp_release_in_ready",  64'(in_ready),  64'd1);
    checkOutput("bp_release_out_valid", 64'(out_valid), 64'd0);
    checkOutput("idle_holds_product",   product,        64'd63);

    // Clock enable low for three cycles mid-RUN stretches latency by three.
    applyStimulus(32'd1000, 32'hFFFF_FFFD, 1'b1);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    en = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checkOutput("en_low_out_valid", 64'(out_valid), 64'd0);
    en = 1'b1;
    waitResult(res, lat);
    checkOutput("en_stall_product", res, 64'hFFFF_FFFF_FFFF_F448);
    checkOutput("en_stall_latency", 64'(lat + 8), 64'(LATENCY + 3));
    releaseResult();

    // Reset at iteration 8 aborts the operation and clears the product.
    applyStimulus(32'd5, 32'd7, 1'b0);
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_in_ready",  64'(in_ready),  64'd1);
    checkOutput("abort_out_valid", 64'(out_valid), 64'd0);
    checkOutput("abort_product",   product,        64'd0);
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checkOutput("abort_no_out_valid", 64'(seen), 64'd0);
    applyStimulus(32'd13, 32'd20, 1'b1);
    waitResult(res, lat);
    checkOutput("post_reset_product", res, 64'd260);
    checkOutput("post_reset_latency", 64'(lat), 64'(LATENCY));
    releaseResult();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
